// File: rtl/rmii_rx_deframer_pkg.sv
// Shared constants, state encoding and helpers for the RMII receive deframer.
package rmii_rx_deframer_pkg;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
  // Register value left by the reflected (shift-right) engine after a frame plus its good FCS
  localparam logic [31:0] CRC32_RESIDUE  = 32'hDEBB20E3;
  localparam int          LEN_W          = 11;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/rmii_rx_deframer_if.sv
// PHY-side RMII receive pins and MAC-side byte stream of the deframer.
interface rmii_rx_deframer_if;
  import rmii_rx_deframer_pkg::*;

  logic             rmii_crs_dv;
  logic             rmii_rx_err;
  logic [1:0]       rmii_rxd;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_sof;
  logic             rx_eof;
  logic             rx_crc_ok;
  logic             rx_err;
  logic [LEN_W-1:0] rx_len;

  modport master (
    input  rmii_crs_dv, rmii_rx_err, rmii_rxd,
    output rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_len
  );

  modport slave (
    output rmii_crs_dv, rmii_rx_err, rmii_rxd,
    input  rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_len
  );

endinterface

// File: rtl/rmii_rx_deframer_crc32_d8.sv
// Combinational CRC-32 step over one byte, LSB first (reflected Ethernet form).
module rmii_rx_deframer_crc32_d8
  import rmii_rx_deframer_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  localparam logic [31:0] POLY_R = bitrev32(CRC32_POLY);

  always_comb begin
    o_crc = i_crc;
    for (int i = 0; i < 8; i++)
      o_crc = (o_crc[0] ^ i_data[i]) ? ((o_crc >> 1) ^ POLY_R) : (o_crc >> 1);
  end

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII PHY receive front end: preamble/SFD hunt, dibit-to-byte packing, EOF status.
module rmii_rx_deframer
  import rmii_rx_deframer_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1522,
  parameter int PRE_MIN   = 4
)(
  input  logic               clk_50_mhz,
  input  logic               rst_n,
  rmii_rx_deframer_if.master bus
);

  localparam logic [LEN_W-1:0] L_MIN = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] L_MAX = LEN_W'(MAX_FRAME);
  localparam logic [4:0]       L_PRE = 5'(PRE_MIN);

  state_t           r_state;
  logic             r_crs_dv, r_rx_er;
  logic [1:0]       r_rxd;
  logic             r_c1;
  logic [1:0]       r_d1;
  logic             r_idle_seen;
  logic [4:0]       r_pre_cnt;
  logic             r_prime;
  logic [1:0]       r_dib_idx;
  logic [5:0]       r_sh;
  logic [LEN_W-1:0] r_len;
  logic [31:0]      r_crc;
  logic             r_err;

  logic [7:0]       r_rx_data;
  logic             r_rx_valid, r_rx_sof, r_rx_eof, r_rx_crc_ok, r_rx_err;
  logic [LEN_W-1:0] r_rx_len;

  logic [7:0]       w_byte;
  logic [31:0]      w_crc_nxt;
  logic [LEN_W-1:0] w_len_inc;

  assign w_byte    = {r_d1, r_sh};
  assign w_len_inc = (&r_len) ? r_len : r_len + 1'b1;

  rmii_rx_deframer_crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (w_byte),
    .o_crc  (w_crc_nxt)
  );

  // DATA consumes the previous cycle's dibit (r_d1) so that a first low CRS_DV
  // sample can still be discarded once a second low confirms end of frame.
  always_ff @(posedge clk_50_mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      // carrier assumed present until a real low is sampled after reset
      r_crs_dv    <= 1'b1;
      r_rx_er     <= 1'b0;
      r_rxd       <= '0;
      r_c1        <= 1'b1;
      r_d1        <= '0;
      r_idle_seen <= 1'b0;
      r_pre_cnt   <= '0;
      r_prime     <= 1'b0;
      r_dib_idx   <= '0;
      r_sh        <= '0;
      r_len       <= '0;
      r_crc       <= '1;
      r_err       <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_sof    <= 1'b0;
      r_rx_eof    <= 1'b0;
      r_rx_crc_ok <= 1'b0;
      r_rx_err    <= 1'b0;
      r_rx_len    <= '0;
    end else begin
      r_crs_dv   <= bus.rmii_crs_dv;
      r_rx_er    <= bus.rmii_rx_err;
      r_rxd      <= bus.rmii_rxd;
      r_c1       <= r_crs_dv;
      r_d1       <= r_rxd;
      r_rx_valid <= 1'b0;
      r_rx_sof   <= 1'b0;
      r_rx_eof   <= 1'b0;
      if (!r_crs_dv) r_idle_seen <= 1'b1;

      case (r_state)
        IDLE: begin
          if (r_crs_dv && r_idle_seen) begin
            r_state   <= PREAMBLE;
            r_pre_cnt <= '0;
          end
        end

        PREAMBLE: begin
          if (!r_crs_dv) begin
            r_state <= IDLE;
          end else begin
            case (r_rxd)
              2'b00: ;
              PREAMBLE_DIBIT: if (!(&r_pre_cnt)) r_pre_cnt <= r_pre_cnt + 1'b1;
              SFD_DIBIT: begin
                if (r_pre_cnt >= L_PRE) begin
                  r_state   <= DATA;
                  r_prime   <= 1'b1;
                  r_dib_idx <= '0;
                  r_len     <= '0;
                  r_crc     <= '1;
                  r_err     <= 1'b0;
                end else begin
                  r_state <= DROP;
                end
              end
              default: r_state <= DROP;
            endcase
          end
        end

        DATA: begin
          if (r_rx_er) r_err <= 1'b1;
          if (r_prime) begin
            r_prime <= 1'b0;
          end else if (!r_crs_dv && !r_c1) begin
            r_rx_eof    <= 1'b1;
            r_rx_crc_ok <= (r_crc == CRC32_RESIDUE);
            r_rx_len    <= r_len;
            r_rx_err    <= r_err | r_rx_er | (r_dib_idx != 2'd0) |
                           (r_len < L_MIN) | (r_len > L_MAX);
            r_state     <= IDLE;
          end else begin
            r_dib_idx <= r_dib_idx + 1'b1;
            if (r_dib_idx == 2'd3) begin
              r_crc <= w_crc_nxt;
              r_len <= w_len_inc;
              if (r_len < L_MAX) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= w_byte;
                r_rx_sof   <= (r_len == '0);
              end else begin
                r_err <= 1'b1;
              end
            end else begin
              r_sh <= {r_d1, r_sh[5:2]};
            end
          end
        end

        DROP: begin
          if (!r_crs_dv && !r_c1) r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.rx_sof    = r_rx_sof;
  assign bus.rx_eof    = r_rx_eof;
  assign bus.rx_crc_ok = r_rx_crc_ok;
  assign bus.rx_err    = r_rx_err;
  assign bus.rx_len    = r_rx_len;

endmodule
